// File: rtl/key_result_arbiter_pkg.sv
// Shared types and constants for the key/result arbiter.
// State encoding plus seven-segment glyph constants.
package ksa_pkg;

    typedef enum logic [1:0] {
        ST_SEARCH,
        ST_FOUND,
        ST_EXHAUSTED
    } arb_state_t;

    localparam logic [6:0] SEG_BLANK  = 7'h7F;
    localparam logic [6:0] SEG_DASH   = 7'h3F;
    localparam int         HEX_DIGITS = 6;

endpackage

// File: rtl/key_result_arbiter_if.sv
// Bundle between the decryption cores / display and the arbiter.
// The master drives the core side; the slave is the arbiter.
interface key_result_arbiter_if #(
    parameter int CORE_COUNT = 8,
    parameter int KEY_WIDTH  = 24,
    parameter int CNT_WIDTH  = 32
);
    localparam int IW = $clog2(CORE_COUNT);

    logic                             restart;
    logic [CORE_COUNT-1:0]            core_done;
    logic [CORE_COUNT-1:0]            core_invalid;
    logic [CORE_COUNT*KEY_WIDTH-1:0]  core_key;
    logic [IW-1:0]                    view_sel;

    logic                             stop;
    logic                             found;
    logic                             exhausted;
    logic [IW-1:0]                    winner_idx;
    logic [KEY_WIDTH-1:0]             winner_key;
    logic [CNT_WIDTH-1:0]             search_cycles;
    logic [6:0]                       hex0;
    logic [6:0]                       hex1;
    logic [6:0]                       hex2;
    logic [6:0]                       hex3;
    logic [6:0]                       hex4;
    logic [6:0]                       hex5;

    modport master (
        output restart, core_done, core_invalid,
        output core_key, view_sel,
        input  stop, found, exhausted,
        input  winner_idx, winner_key, search_cycles,
        input  hex0, hex1, hex2, hex3, hex4, hex5
    );

    modport slave (
        input  restart, core_done, core_invalid,
        input  core_key, view_sel,
        output stop, found, exhausted,
        output winner_idx, winner_key, search_cycles,
        output hex0, hex1, hex2, hex3, hex4, hex5
    );

endinterface

// File: rtl/key_result_arbiter_hex.sv
// Nibble to active-low seven-segment glyph {g,f,e,d,c,b,a}.
// Purely combinational.
module hex_to_seven_seg (
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    always_comb begin
        seg = 7'h7F;
        unique case (nibble)
            4'h0: seg = 7'h40;
            4'h1: seg = 7'h79;
            4'h2: seg = 7'h24;
            4'h3: seg = 7'h30;
            4'h4: seg = 7'h19;
            4'h5: seg = 7'h12;
            4'h6: seg = 7'h02;
            4'h7: seg = 7'h78;
            4'h8: seg = 7'h00;
            4'h9: seg = 7'h10;
            4'hA: seg = 7'h08;
            4'hB: seg = 7'h03;
            4'hC: seg = 7'h46;
            4'hD: seg = 7'h21;
            4'hE: seg = 7'h06;
            4'hF: seg = 7'h0E;
        endcase
    end

endmodule

// File: rtl/key_result_arbiter.sv
// Latches the first winning decryption core, drives the global stop
// and owns the six-digit key display.
module key_result_arbiter
    import ksa_pkg::*;
#(
    parameter int CORE_COUNT = 8,
    parameter int KEY_WIDTH  = 24,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    key_result_arbiter_if.slave   bus
);

    localparam int IW    = $clog2(CORE_COUNT);
    localparam int SLOTS = 1 << IW;

    arb_state_t            state_q, state_d;
    logic [CORE_COUNT-1:0] inv_mask_q, inv_mask_d;
    logic                  stop_q, stop_d;
    logic                  found_q, found_d;
    logic                  exhausted_q, exhausted_d;
    logic [IW-1:0]         winner_idx_q, winner_idx_d;
    logic [KEY_WIDTH-1:0]  winner_key_q, winner_key_d;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
    logic [6:0]            hex_q [HEX_DIGITS];
    logic [6:0]            hex_d [HEX_DIGITS];
    logic [6:0]            glyph [HEX_DIGITS];

    logic [KEY_WIDTH-1:0]  key_arr [SLOTS];
    logic [SLOTS-1:0]      slot_ok;
    logic [KEY_WIDTH-1:0]  src_key;
    logic                  src_blank;
    logic                  src_dash;

    function automatic logic [IW-1:0] first_set(
        input logic [CORE_COUNT-1:0] v
    );
        first_set = '0;
        for (int i = CORE_COUNT - 1; i >= 0; i--) begin
            if (v[i]) first_set = IW'(i);
        end
    endfunction

    // Pad the key table to a power of two so view_sel can index it directly.
    for (genvar g = 0; g < SLOTS; g++) begin : g_slot
        if (g < CORE_COUNT) begin : g_core
            assign key_arr[g] = bus.core_key[g*KEY_WIDTH +: KEY_WIDTH];
            assign slot_ok[g] = 1'b1;
        end else begin : g_pad
            assign key_arr[g] = '0;
            assign slot_ok[g] = 1'b0;
        end
    end

    always_comb begin
        state_d      = state_q;
        inv_mask_d   = inv_mask_q;
        winner_idx_d = winner_idx_q;
        winner_key_d = winner_key_q;
        cnt_d        = cnt_q;
        if (bus.restart) begin
            state_d    = ST_SEARCH;
            inv_mask_d = '0;
            cnt_d      = '0;
        end else if (state_q == ST_SEARCH) begin
            cnt_d      = (&cnt_q) ? cnt_q : cnt_q + CNT_WIDTH'(1);
            inv_mask_d = inv_mask_q | bus.core_invalid;
            if (|bus.core_done) begin
                state_d      = ST_FOUND;
                winner_idx_d = first_set(bus.core_done);
                winner_key_d = key_arr[winner_idx_d];
            end else if (&inv_mask_d) begin
                state_d = ST_EXHAUSTED;
            end
        end
        stop_d      = (state_d != ST_SEARCH);
        found_d     = (state_d == ST_FOUND);
        exhausted_d = (state_d == ST_EXHAUSTED);
    end

    always_comb begin
        src_key   = '0;
        src_blank = 1'b0;
        src_dash  = 1'b0;
        case (state_q)
            ST_SEARCH: begin
                src_key   = key_arr[bus.view_sel];
                src_blank = !slot_ok[bus.view_sel];
            end
            ST_FOUND:     src_key   = winner_key_q;
            ST_EXHAUSTED: src_dash  = 1'b1;
            default:      src_blank = 1'b1;
        endcase
    end

    for (genvar d = 0; d < HEX_DIGITS; d++) begin : g_dig
        hex_to_seven_seg u_dec (
            .nibble (src_key[4*d +: 4]),
            .seg    (glyph[d])
        );
        assign hex_d[d] = src_dash  ? SEG_DASH  :
                          src_blank ? SEG_BLANK : glyph[d];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_SEARCH;
            inv_mask_q   <= '0;
            stop_q       <= 1'b0;
            found_q      <= 1'b0;
            exhausted_q  <= 1'b0;
            winner_idx_q <= '0;
            winner_key_q <= '0;
            cnt_q        <= '0;
            for (int d = 0; d < HEX_DIGITS; d++) hex_q[d] <= SEG_BLANK;
        end else begin
            state_q      <= state_d;
            inv_mask_q   <= inv_mask_d;
            stop_q       <= stop_d;
            found_q      <= found_d;
            exhausted_q  <= exhausted_d;
            winner_idx_q <= winner_idx_d;
            winner_key_q <= winner_key_d;
            cnt_q        <= cnt_d;
            for (int d = 0; d < HEX_DIGITS; d++) hex_q[d] <= hex_d[d];
        end
    end

    assign bus.stop          = stop_q;
    assign bus.found         = found_q;
    assign bus.exhausted     = exhausted_q;
    assign bus.winner_idx    = winner_idx_q;
    assign bus.winner_key    = winner_key_q;
    assign bus.search_cycles = cnt_q;
    assign bus.hex0          = hex_q[0];
    assign bus.hex1          = hex_q[1];
    assign bus.hex2          = hex_q[2];
    assign bus.hex3          = hex_q[3];
    assign bus.hex4          = hex_q[4];
    assign bus.hex5          = hex_q[5];

endmodule
